// File: rtl/hwpe_ctrl_uloop_seq_pkg.sv
// ============================================================================
// Module   : hwpe_ctrl_uloop_seq_pkg
// Brief    : Shared types and constants for the micro-loop job sequencer.
//            Covers the engine control/flag bundles, the buffered job
//            record and the sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hwpe_ctrl_uloop_seq_pkg;

    localparam int unsigned ULOOP_NB_REG         = 4;
    localparam int unsigned ULOOP_NB_LOOPS       = 6;
    localparam int unsigned ULOOP_REG_WIDTH      = 32;
    localparam int unsigned ULOOP_CNT_WIDTH      = 12;
    localparam int unsigned ULOOP_SEQ_FIFO_DEPTH = 2;

    // Controls towards the micro-loop engine
    typedef struct packed {
        logic enable;
        logic clear;
    } ctrl_uloop_t;

    // Flags coming back from the micro-loop engine (pre-step values)
    typedef struct packed {
        logic                                              done;
        logic [ULOOP_NB_REG-1:0][ULOOP_REG_WIDTH-1:0]     offs;
        logic [ULOOP_NB_LOOPS-1:0][ULOOP_CNT_WIDTH-1:0]   idx;
    } flags_uloop_t;

    // One buffered engine step handed to the streamer address logic
    typedef struct packed {
        logic [ULOOP_NB_REG-1:0][ULOOP_REG_WIDTH-1:0]     offs;
        logic [ULOOP_NB_LOOPS-1:0][ULOOP_CNT_WIDTH-1:0]   idx;
        logic                                              last;
    } uloop_job_t;

    // Sequencer states
    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_CLEAR = 2'd1,
        SEQ_RUN   = 2'd2,
        SEQ_DRAIN = 2'd3
    } uloop_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/hwpe_ctrl_uloop_seq_fifo.sv
// ============================================================================
// Module   : hwpe_ctrl_uloop_seq_fifo
// Brief    : Generic first-word fall-through FIFO with flush. The head entry
//            is presented on data_o whenever the FIFO is not empty; data_o
//            reads as zero while empty. DEPTH must be a power of two >= 2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hwpe_ctrl_uloop_seq_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type         job_t = logic
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  job_t                   data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output job_t                   data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned        c_ptr_w      = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_full_count = (c_ptr_w + 1)'(DEPTH);

    job_t               r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full_o    = (r_count == c_full_count);
    assign empty_o   = (r_count == '0);
    assign count_o   = r_count;
    // Flush wins over both ports; a pop on an empty FIFO is a no-op, so a
    // push into an empty FIFO only becomes visible the following cycle.
    assign w_do_push = push_i & ~full_o & ~flush_i;
    assign w_do_pop  = pop_i & ~empty_o & ~flush_i;
    assign data_o    = empty_o ? '0 : r_mem[r_rptr];

    // Entry storage; contents are only meaningful between the pointers
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (power of two)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/hwpe_ctrl_uloop_seq.sv
// ============================================================================
// Module   : hwpe_ctrl_uloop_seq
// Brief    : Micro-loop job sequencer. Steps the micro-loop engine only when
//            the job buffer has room, records every step as a job and hands
//            jobs downstream over valid/ready. Downstream backpressure stalls
//            the engine without dropping steps.
//            Optional macro HWPE_CTRL_ULOOP_SEQ_STATS_EN adds job and stall
//            counters (jobs_cnt_o, stall_cnt_o).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hwpe_ctrl_uloop_seq
    import hwpe_ctrl_uloop_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = ULOOP_SEQ_FIFO_DEPTH,
    parameter int unsigned NB_REG     = ULOOP_NB_REG,
    parameter int unsigned NB_LOOPS   = ULOOP_NB_LOOPS,
    parameter int unsigned REG_WIDTH  = ULOOP_REG_WIDTH,
    parameter int unsigned CNT_WIDTH  = ULOOP_CNT_WIDTH
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         abort_i,
    output logic         busy_o,
    output logic         done_o,
    output ctrl_uloop_t  uloop_ctrl_o,
    input  flags_uloop_t uloop_flags_i,
    output logic         job_valid_o,
    input  logic         job_ready_i,
    output uloop_job_t   job_o
`ifdef HWPE_CTRL_ULOOP_SEQ_STATS_EN
    ,
    output logic [31:0]  jobs_cnt_o,
    output logic [31:0]  stall_cnt_o
`endif
);

    uloop_seq_state_t              r_state;
    logic                          r_abort_clr;
    logic                          w_abort;
    logic                          w_enable;
    logic                          w_pop;
    logic                          w_last_pop;
    logic                          w_fifo_full;
    logic                          w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   w_unused_fifo_count;
    uloop_job_t                    w_push_job;

    // Abort only has meaning while a run is in progress
    assign w_abort    = abort_i & (r_state != SEQ_IDLE);
    // Engine steps only when a buffer slot is guaranteed; never depends on ready
    assign w_enable   = (r_state == SEQ_RUN) & ~w_fifo_full & ~w_abort;
    assign w_pop      = job_valid_o & job_ready_i & ~w_abort;
    assign w_last_pop = w_pop & job_o.last;

    assign busy_o             = (r_state != SEQ_IDLE);
    assign done_o             = (r_state == SEQ_DRAIN) & w_last_pop;
    assign uloop_ctrl_o.enable = w_enable;
    assign uloop_ctrl_o.clear  = (r_state == SEQ_CLEAR) | r_abort_clr;
    assign job_valid_o        = ~w_fifo_empty;

    // Capture the engine's pre-step flags as the job for this step
    always_comb begin
        w_push_job = '0;
        for (int r = 0; r < NB_REG; r++) begin
            w_push_job.offs[r] = uloop_flags_i.offs[r][REG_WIDTH-1:0];
        end
        for (int l = 0; l < NB_LOOPS; l++) begin
            w_push_job.idx[l] = uloop_flags_i.idx[l][CNT_WIDTH-1:0];
        end
        w_push_job.last = uloop_flags_i.done;
    end

    hwpe_ctrl_uloop_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .job_t (uloop_job_t)
    ) i_job_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_enable),
        .data_i  (w_push_job),
        .pop_i   (w_pop),
        .flush_i (w_abort),
        .data_o  (job_o),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_unused_fifo_count)
    );

    // Sequencer FSM; abort overrides every transition and schedules a clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= SEQ_IDLE;
            r_abort_clr <= 1'b0;
        end else begin
            r_abort_clr <= w_abort;
            if (w_abort) begin
                r_state <= SEQ_IDLE;
            end else begin
                case (r_state)
                    SEQ_IDLE:  if (start_i) r_state <= SEQ_CLEAR;
                    SEQ_CLEAR: r_state <= SEQ_RUN;
                    SEQ_RUN:   if (w_enable && uloop_flags_i.done) r_state <= SEQ_DRAIN;
                    SEQ_DRAIN: if (w_last_pop) r_state <= SEQ_IDLE;
                    default:   r_state <= SEQ_IDLE;
                endcase
            end
        end
    end

`ifdef HWPE_CTRL_ULOOP_SEQ_STATS_EN
    logic [31:0] r_jobs_cnt;
    logic [31:0] r_stall_cnt;

    assign jobs_cnt_o  = r_jobs_cnt;
    assign stall_cnt_o = r_stall_cnt;

    // Saturating job/stall counters, cleared at the start of each run only
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_jobs_cnt  <= '0;
            r_stall_cnt <= '0;
        end else if (r_state == SEQ_CLEAR) begin
            r_jobs_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop && (r_jobs_cnt != '1)) begin
                r_jobs_cnt <= r_jobs_cnt + 32'd1;
            end
            if ((r_state == SEQ_RUN) && w_fifo_full && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/hwpe_ctrl_uloop_seq.md
Name: hwpe_ctrl_uloop_seq

Overview:
Drives the micro-loop engine's control interface (`ctrl_uloop_t`) and consumes its flags (`flags_uloop_t`). Each engine step becomes a buffered job (offsets, indices, last marker) that is handed to the streamer address logic over a valid/ready handshake. Engine stepping is throttled by free buffer space, so downstream backpressure stalls the micro-loop without losing any step. Sits between the HWPE controller FSM and the streamer source/sink address generators.

Parameters:
- FIFO_DEPTH, 2: job buffer entries (power of two, ≥2).
- NB_REG, ULOOP_NB_REG: number of offset registers carried per job.
- NB_LOOPS, ULOOP_NB_LOOPS: number of loop indices carried per job.
- REG_WIDTH, ULOOP_REG_WIDTH: offset width.
- CNT_WIDTH, ULOOP_CNT_WIDTH: index width.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: asynchronous active-high reset.
- start_i, in, 1: start one micro-loop run (sampled in IDLE only).
- abort_i, in, 1: abandon the current run and flush buffered jobs.
- busy_o, out, 1: high in every state except IDLE.
- done_o, out, 1: one-cycle pulse when the last job is accepted downstream.
- uloop_ctrl_o, out, ctrl_uloop_t: `enable`/`clear` to the engine.
- uloop_flags_i, in, flags_uloop_t: `done`/`offs`/`idx` from the engine.
- job_valid_o, out, 1: job available.
- job_ready_i, in, 1: downstream accepts the job.
- job_o, out, uloop_job_t: `offs[NB_REG][REG_WIDTH]`, `idx[NB_LOOPS][CNT_WIDTH]`, `last`.

Behaviour:
- Reset values: busy_o=0, done_o=0, job_valid_o=0, job_o=0, uloop_ctrl_o.enable=0, uloop_ctrl_o.clear=0; FSM=IDLE; FIFO empty.
- The FSM has four states: IDLE, CLEAR, RUN, DRAIN.
- IDLE:
  - start_i=1 → CLEAR.
  - start_i is ignored in any other state.
- CLEAR:
  - uloop_ctrl_o.clear=1 for exactly one cycle, then → RUN.
  - enable=0 in this state.
- RUN:
  - enable = ~fifo_full. This is combinational from the registered FIFO count; there is no dependence on job_ready_i.
  - In every cycle where enable=1, push {uloop_flags_i.offs, uloop_flags_i.idx, last=uloop_flags_i.done} into the FIFO in the same cycle. These are the pre-step values for that step.
  - A push with last=1 → DRAIN. enable=0 from the next cycle.
- DRAIN:
  - enable=0.
  - When the FIFO pops an entry with last=1 (job_valid_o & job_ready_i & job_o.last): done_o=1 in that same cycle, → IDLE.
- FIFO behaviour:
  - First-word fall-through: job_valid_o = ~empty, and job_o is the head entry. No combinational path from job_ready_i to the enable signal.
  - Simultaneous push and pop when full: not allowed, because enable is gated by full.
  - Simultaneous push and pop when empty: the entry becomes visible the following cycle. Zero latency through an empty FIFO is not required.
  - Push latency: enable cycle → job_valid_o one cycle later.
- abort_i (any state except IDLE; highest priority):
  - Flush the FIFO and force enable=0.
  - Drive uloop_ctrl_o.clear=1 for one cycle.
  - → IDLE. done_o is not asserted.
  - In IDLE, abort_i is ignored.
- Asynchronous reset mid-run returns all state to reset values immediately.
- Job count: every engine step produces exactly one job, including steps with no register update. The job count for a run equals the engine's total step count, including the terminate step.

Optional Feature:
- Macro: HWPE_CTRL_ULOOP_SEQ_STATS_EN.
- When defined:
  - Adds output jobs_cnt_o [31:0]: number of jobs popped since the last start.
  - Adds output stall_cnt_o [31:0]: cycles in RUN with fifo_full=1.
  - Both counters clear in the CLEAR state and saturate at 2^32-1.
  - abort_i does not clear them.
- When undefined: the ports and counters do not exist, with no other behavioural change.

Decomposition:
- hwpe_ctrl_package gains:
  - typedef uloop_job_t (offs, idx, last).
  - localparam ULOOP_SEQ_FIFO_DEPTH = 2.
  - The FSM state enum type.
- Sub-module hwpe_ctrl_uloop_seq_fifo: generic FWFT FIFO with push, pop, flush, full, empty and count, parameterised on depth and on a `job_t` type parameter.
- FSM and stats counters stay in the top module.

Test Plan:
1. Engine stub with 3 steps (done=1 on step 3), job_ready_i=1 constantly → exactly 3 jobs, last only on job 3; done_o pulses once, on job 3's handshake cycle; busy_o falls the next cycle.
2. Same stub, job_ready_i=0 for 10 cycles after start → enable asserted exactly FIFO_DEPTH=2 times, then held 0. Releasing ready drains the FIFO in order, with offs values 0x10, 0x20, 0x30 preserved.
3. abort_i during RUN with 1 job buffered → job_valid_o=0 next cycle, clear pulses one cycle, FSM=IDLE, no done_o. A subsequent start issues clear again and runs cleanly.
4. start_i held high during RUN and DRAIN → no extra clear pulse and no restart. After done_o, a new start_i is accepted.
5. Asynchronous rst_i asserted mid-RUN between clock edges → all outputs 0 before the next edge; the FIFO is empty after reset releases.
6. With HWPE_CTRL_ULOOP_SEQ_STATS_EN, 5-step run with ready low for 4 cycles → jobs_cnt_o=5, stall_cnt_o equals the measured full-stall cycles. Counters are unchanged by abort_i and reset by the next start.
